// File: rtl/des_pkg.sv
`default_nettype none
// ============================================================================
// Module      : des_pkg
// Description : DES S-box tables, P permutation and pipeline depth bounds.
//               P is applied only when DES_SBOX_PERMUTE_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
package des_pkg;

  localparam int PIPE_DEPTH_MIN = 1;
  localparam int PIPE_DEPTH_MAX = 4;

  // 64 nibbles per box, row-major (row*16 + col), entry 0 in the top nibble.
  localparam logic [255:0] SBOX_TABLE [1:8] = '{
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
  };

  localparam int P_TABLE [0:31] = '{
    16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25
  };

  function automatic logic [0:31] p_permute(input logic [0:31] x);
    logic [0:31] y;
    y = '0;
    for (int i = 0; i < 32; i++) begin
      y[i] = x[P_TABLE[i] - 1];
    end
    return y;
  endfunction

endpackage
`default_nettype wire

// File: rtl/des_sbox_lut.sv
`default_nettype none
// ============================================================================
// Module      : des_sbox_lut
// Description : One DES S-box; 6-bit segment in, 4-bit substitution out.
// Revision    : 1.0 - initial release
// ============================================================================
module des_sbox_lut
  import des_pkg::*;
#(
  parameter int SBOX_ID = 1
) (
  input  logic [5:0] din,
  output logic [3:0] dout
);

  localparam logic [255:0] c_sbox_table = SBOX_TABLE[SBOX_ID];

  logic [5:0] w_idx;

  if (SBOX_ID < 1 || SBOX_ID > 8) begin : g_id_check
    $error("des_sbox_lut: SBOX_ID must be 1..8");
  end

  // Row is the outer bit pair, column the inner four; entry n lives at nibble 63-n.
  assign w_idx = {din[5], din[0], din[4:1]};
  assign dout  = c_sbox_table[{~w_idx, 2'b00} +: 4];

endmodule
`default_nettype wire

// File: rtl/des_substitution_unit.sv
`default_nettype none
// ============================================================================
// Module      : des_substitution_unit
// Description : DES S-box substitution followed by an elastic valid/ready
//               pipeline. Define DES_SBOX_PERMUTE_EN to apply the P permutation.
// Revision    : 1.0 - initial release
// ============================================================================
module des_substitution_unit
  import des_pkg::*;
#(
  parameter int PIPE_DEPTH = 2,
  parameter int TAG_WIDTH  = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [0:47]          right_xor_key_din,
  input  logic [TAG_WIDTH-1:0] tag_din,
  input  logic                 valid_din,
  output logic                 ready_dout,
  output logic [0:31]          sbox_dout,
  output logic [TAG_WIDTH-1:0] tag_dout,
  output logic                 valid_dout,
  input  logic                 ready_din,
  output logic [2:0]           occupancy_dout
);

  logic [0:31]          w_sub;
  logic [0:31]          w_stage_in;
  logic [PIPE_DEPTH-1:0] w_valid;
  logic [PIPE_DEPTH-1:0] w_load;
  logic [0:31]          w_data [PIPE_DEPTH];
  logic [TAG_WIDTH-1:0] w_tag  [PIPE_DEPTH];
  logic                 w_in_hs;
  logic                 w_out_hs;
  logic [2:0]           r_occ;

  if (PIPE_DEPTH < PIPE_DEPTH_MIN || PIPE_DEPTH > PIPE_DEPTH_MAX) begin : g_depth_check
    $error("des_substitution_unit: PIPE_DEPTH out of range");
  end

  for (genvar g = 0; g < 8; g++) begin : g_sbox
    des_sbox_lut #(
      .SBOX_ID (g + 1)
    ) u_lut (
      .din  (right_xor_key_din[6*g +: 6]),
      .dout (w_sub[4*g +: 4])
    );
  end

`ifdef DES_SBOX_PERMUTE_EN
  assign w_stage_in = p_permute(w_sub);
`else
  assign w_stage_in = w_sub;
`endif

  for (genvar k = 0; k < PIPE_DEPTH; k++) begin : g_stage
    logic                 r_valid;
    logic [0:31]          r_data;
    logic [TAG_WIDTH-1:0] r_tag;
    logic                 w_in_valid;
    logic [0:31]          w_in_data;
    logic [TAG_WIDTH-1:0] w_in_tag;

    if (k == 0) begin : g_head
      assign w_in_valid = valid_din;
      assign w_in_data  = w_stage_in;
      assign w_in_tag   = tag_din;
    end else begin : g_body
      assign w_in_valid = w_valid[k-1];
      assign w_in_data  = w_data[k-1];
      assign w_in_tag   = w_tag[k-1];
    end

    // A stage can take a word if downstream drains or any stage from here on is empty.
    assign w_load[k] = ready_din | ~(&w_valid[PIPE_DEPTH-1:k]);

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        r_valid <= 1'b0;
        r_data  <= '0;
        r_tag   <= '0;
      end else if (w_load[k]) begin
        r_valid <= w_in_valid;
        r_data  <= w_in_data;
        r_tag   <= w_in_tag;
      end
    end

    assign w_valid[k] = r_valid;
    assign w_data[k]  = r_data;
    assign w_tag[k]   = r_tag;
  end

  assign ready_dout = w_load[0];
  assign valid_dout = w_valid[PIPE_DEPTH-1];
  assign sbox_dout  = w_data[PIPE_DEPTH-1];
  assign tag_dout   = w_tag[PIPE_DEPTH-1];

  assign w_in_hs  = valid_din & ready_dout;
  assign w_out_hs = valid_dout & ready_din;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_occ <= 3'd0;
    end else if (w_in_hs && !w_out_hs) begin
      r_occ <= r_occ + 3'd1;
    end else if (!w_in_hs && w_out_hs) begin
      r_occ <= r_occ - 3'd1;
    end
  end

  assign occupancy_dout = r_occ;

endmodule
`default_nettype wire

// File: tb/tb_des_substitution_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_des_substitution_unit
// Description : Self-checking bench for des_substitution_unit against a
//               queue-based reference model (honours DES_SBOX_PERMUTE_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_des_substitution_unit;

  localparam int DEPTH = 2;

  localparam int SB [8][64] = '{
    '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7,     0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
      4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0,     15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
    '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10,     3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
      0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15,     13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
    '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8,     13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
      13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7,     1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
    '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15,     13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
      10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4,     3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
    '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9,     14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
      4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14,     11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
    '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11,     10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
      9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6,     4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
    '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1,     13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
      1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2,     6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
    '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7,     1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
      7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8,     2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}
  };

  localparam int PT [32] = '{16,7,20,21,29,12,28,17,1,15,23,26,5,18,31,10,
                             2,8,24,14,32,27,3,9,19,13,30,6,22,11,4,25};

  typedef struct {
    logic [31:0] d;
    logic [3:0]  t;
    int          ready_at;
  } exp_t;

  logic        clk;
  logic        reset_n;
  logic [0:47] right_xor_key_din;
  logic [3:0]  tag_din;
  logic        valid_din;
  logic        ready_dout;
  logic [0:31] sbox_dout;
  logic [3:0]  tag_dout;
  logic        valid_dout;
  logic        ready_din;
  logic [2:0]  occupancy_dout;

  exp_t q[$];
  int   edge_n      = 0;
  int   n_assert    = 0;
  int   n_fail      = 0;
  int   n_delivered = 0;

  des_substitution_unit #(
    .PIPE_DEPTH (DEPTH),
    .TAG_WIDTH  (4)
  ) dut (
    .clk               (clk),
    .reset             (reset_n),
    .right_xor_key_din (right_xor_key_din),
    .tag_din           (tag_din),
    .valid_din         (valid_din),
    .ready_dout        (ready_dout),
    .sbox_dout         (sbox_dout),
    .tag_dout          (tag_dout),
    .valid_dout        (valid_dout),
    .ready_din         (ready_din),
    .occupancy_dout    (occupancy_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ref_perm(input logic [31:0] x);
    logic [31:0] y;
    y = '0;
    for (int i = 0; i < 32; i++) begin
      if (((x >> (32 - PT[i])) & 32'd1) != 0) y = y | (32'd1 << (31 - i));
    end
    return y;
  endfunction

  function automatic logic [31:0] ref_sub(input logic [47:0] k);
    logic [31:0] r;
    int seg, row, col;
    r = '0;
    for (int s = 0; s < 8; s++) begin
      seg = int'((k >> (42 - 6 * s)) & 48'h3F);
      row = ((seg >> 5) & 1) * 2 + (seg & 1);
      col = (seg >> 1) & 15;
      r   = r | (32'(SB[s][row * 16 + col]) << (28 - 4 * s));
    end
`ifdef DES_SBOX_PERMUTE_EN
    r = ref_perm(r);
`endif
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive, check at the falling edge, then advance the model.
  task automatic step(input logic vin, input logic [47:0] key, input logic [3:0] tg,
                      input logic rin, output logic acc);
    logic ev, er;
    valid_din = vin; right_xor_key_din = key; tag_din = tg; ready_din = rin;
    @(negedge clk);
    ev = (q.size() > 0) && (edge_n >= q[0].ready_at);
    er = (q.size() < DEPTH) || rin;
    chk("ready_dout", 32'(ready_dout), 32'(er));
    chk("valid_dout", 32'(valid_dout), 32'(ev));
    chk("occupancy", 32'(occupancy_dout), 32'(q.size()));
    if (ev) begin
      chk("sbox_dout", sbox_dout, q[0].d);
      chk("tag_dout", 32'(tag_dout), 32'(q[0].t));
    end
    @(posedge clk);
    edge_n++;
    if (ev && rin) begin
      void'(q.pop_front());
      n_delivered++;
    end
    acc = vin && er;
    if (acc) q.push_back('{d: ref_sub(key), t: tg, ready_at: edge_n + DEPTH - 1});
    #1;
  endtask

  task automatic idle(input logic rin);
    logic a;
    step(1'b0, 48'h0, 4'h0, rin, a);
  endtask

  initial begin
    logic        a;
    logic [47:0] k;
    int          base, i, guard;

    reset_n = 1'b0; valid_din = 1'b0; right_xor_key_din = '0; tag_din = '0; ready_din = 1'b0;
    #3;
    chk("rst_valid", 32'(valid_dout), 32'd0);
    chk("rst_occ", 32'(occupancy_dout), 32'd0);
    chk("rst_sbox", sbox_dout, 32'd0);
    chk("rst_tag", 32'(tag_dout), 32'd0);
    chk("rst_ready", 32'(ready_dout), 32'd1);
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); edge_n++; #1;

    // All-zero key
    step(1'b1, 48'h0, 4'h3, 1'b1, a);
    repeat (DEPTH - 1) idle(1'b1);
`ifdef DES_SBOX_PERMUTE_EN
    chk("zero_key_sbox", sbox_dout, ref_perm(32'hEFA72C4D));
`else
    chk("zero_key_sbox", sbox_dout, 32'hEFA72C4D);
`endif
    chk("zero_key_tag", 32'(tag_dout), 32'h3);
    chk("zero_key_valid", 32'(valid_dout), 32'd1);
    idle(1'b1);

    // Segment 7 row/column corners
    step(1'b1, 48'hFC0, 4'h1, 1'b1, a);
    repeat (DEPTH - 1) idle(1'b1);
`ifndef DES_SBOX_PERMUTE_EN
    chk("seg7_all_ones", 32'(sbox_dout[24:27]), 32'd12);
`endif
    idle(1'b1);
    step(1'b1, 48'h040, 4'h2, 1'b1, a);
    repeat (DEPTH - 1) idle(1'b1);
`ifndef DES_SBOX_PERMUTE_EN
    chk("seg7_row1_col0", 32'(sbox_dout[24:27]), 32'd13);
`endif
    idle(1'b1);

    // Backpressure: only DEPTH words fit, then drain in order
    base = n_delivered;
    step(1'b1, {16'($urandom()), $urandom()}, 4'hA, 1'b0, a);
    step(1'b1, {16'($urandom()), $urandom()}, 4'hB, 1'b0, a);
    step(1'b1, {16'($urandom()), $urandom()}, 4'hC, 1'b0, a);
    chk("full_reject", 32'(a), 32'd0);
    idle(1'b0);
    repeat (DEPTH + 1) idle(1'b1);
    chk("bp_delivered", 32'(n_delivered - base), 32'(DEPTH));
    chk("bp_occ_zero", 32'(occupancy_dout), 32'd0);

    // Full-rate streaming
    for (int j = 0; j < 8; j++) begin
      step(1'b1, {16'($urandom()), $urandom()}, 4'(j), 1'b1, a);
      chk("stream_accept", 32'(a), 32'd1);
    end
    repeat (DEPTH + 1) idle(1'b1);

    // 16 words with random downstream readiness
    base = n_delivered; i = 0; guard = 0;
    k = {16'($urandom()), $urandom()};
    while (i < 16 && guard < 400) begin
      step(1'b1, k, 4'(i), 1'($urandom_range(0, 1)), a);
      if (a) begin
        i++;
        k = {16'($urandom()), $urandom()};
      end
      guard++;
    end
    chk("rand_all_accepted", 32'(i), 32'd16);
    guard = 0;
    while (q.size() > 0 && guard < 100) begin
      idle(1'($urandom_range(0, 1)));
      guard++;
    end
    chk("rand_delivered", 32'(n_delivered - base), 32'd16);

    // Asynchronous reset with words in flight
    step(1'b1, {16'($urandom()), $urandom()}, 4'h5, 1'b0, a);
    step(1'b1, {16'($urandom()), $urandom()}, 4'h6, 1'b0, a);
    valid_din = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chk("arst_valid", 32'(valid_dout), 32'd0);
    chk("arst_occ", 32'(occupancy_dout), 32'd0);
    chk("arst_sbox", sbox_dout, 32'd0);
    chk("arst_tag", 32'(tag_dout), 32'd0);
    chk("arst_ready", 32'(ready_dout), 32'd1);
    q.delete();
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); edge_n++; #1;
    step(1'b1, 48'h0, 4'h7, 1'b1, a);
    repeat (DEPTH - 1) idle(1'b1);
    chk("post_rst_valid", 32'(valid_dout), 32'd1);
    chk("post_rst_tag", 32'(tag_dout), 32'h7);
    repeat (2) idle(1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
